// File: rtl/gpio_in_debounce.sv
// GPIO input block: 2-flop sync, per-bit debounce, W1C edge flags, 4-word register bank, maskable irq.
// Latency: pin to LEVEL 2+DEBOUNCE_CYCLES cycles, read data 1 cycle; no backpressure, every access accepted.
module gpio_in_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  input  logic             wen,
  input  logic             ren,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic [WIDTH-1:0] rd_sel;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

  // Each bit counts consecutive cycles of disagreement; any agreement restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
      end else if (sync2[i] == stable[i] || cnt == CNT_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign accept[i] = (sync2[i] != stable[i]) && (cnt == CNT_MAX);
  end

  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    if (wen && addr == 2'd1) rise_clr = wdata[WIDTH-1:0];
    if (wen && addr == 2'd2) fall_clr = wdata[WIDTH-1:0];
  end

  always_comb begin
    case (addr)
      2'd0:    rd_sel = stable;
      2'd1:    rd_sel = rise;
      2'd2:    rd_sel = fall;
      default: rd_sel = mask;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
      mask   <= '0;
      rdata  <= '0;
      irq    <= 1'b0;
    end else begin
      stable <= stable ^ accept;
      // A new edge in the same cycle as its W1C must survive the clear.
      rise   <= (rise & ~rise_clr) | (accept & sync2);
      fall   <= (fall & ~fall_clr) | (accept & ~sync2);
      if (wen && addr == 2'd3) mask <= wdata[WIDTH-1:0];
      if (ren) rdata <= 32'(rd_sel);
      irq    <= |((rise | fall) & mask);
    end
  end

endmodule
